// File: rtl/mult_sequencer_pkg.sv
// mult_sequencer_pkg
//   Shared definitions for the multi-cycle multiply unit and the controller
//   that drives it: sequencer state encodings and the MIPS SPECIAL funct codes
//   the controller decodes into start / is_signed / wr_hi / wr_lo.
package mult_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;

endpackage

// File: rtl/mult_sequencer.sv
// mult_sequencer
//   Radix-2 shift-add multiplier for MULT/MULTU plus the HI/LO register pair
//   read by MFHI/MFLO and written by MTHI/MTLO. A multiply takes a fixed
//   WIDTH+1 cycles: WIDTH add/shift steps on operand magnitudes, then one
//   cycle to apply the sign and commit {hi,lo}.
// Ports
//   clk        rising-edge clock
//   reset      asynchronous reset, active low (0 = reset)
//   start      begin a multiply (accepted only when idle)
//   is_signed  1 = MULT (two's complement), 0 = MULTU
//   a, b       operands (rs, rt), sampled with start
//   cancel     synchronous abort of an in-flight multiply; hi/lo untouched
//   wr_hi      MTHI strobe (ignored while busy)
//   wr_lo      MTLO strobe (ignored while busy)
//   wdata      MTHI/MTLO data
//   hi, lo     HI/LO register contents
//   busy       high while a multiply is in flight
//   done       one-cycle pulse after hi/lo were written by a multiply
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t state, next_state;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   acc_hi;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] raw_prod;
  logic [2*WIDTH-1:0] product;
  logic               start_accept;
  logic               fix_commit;

  // Operand magnitudes. The most negative value negates to itself, which read
  // as unsigned is exactly its magnitude, so no extra bit is needed.
  always_comb begin
    a_mag = a;
    b_mag = b;
    if (is_signed && a[WIDTH-1]) a_mag = -a;
    if (is_signed && b[WIDTH-1]) b_mag = -b;
  end

  // One add/shift step: the carry out of the add becomes the new MSB of the
  // upper accumulator half after the right shift. The multiplier register
  // doubles as the lower product half as its bits are consumed.
  always_comb begin
    step_sum = {1'b0, acc_hi};
    if (mplier[0]) step_sum = {1'b0, acc_hi} + {1'b0, mcand};
    raw_prod = {acc_hi, mplier};
    product  = neg ? -raw_prod : raw_prod;
  end

  assign start_accept = (state == S_IDLE) && start && !cancel;
  assign fix_commit   = (state == S_FIX) && !cancel;
  assign busy         = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (start_accept) next_state = S_RUN;
      S_RUN: begin
        if (cancel)                 next_state = S_IDLE;
        else if (cnt == LAST_STEP)  next_state = S_FIX;
      end
      S_FIX:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc_hi <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
    end else if (start_accept) begin
      mcand  <= a_mag;
      mplier <= b_mag;
      acc_hi <= '0;
      cnt    <= '0;
      neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if ((state == S_RUN) && !cancel) begin
      acc_hi <= step_sum[WIDTH:1];
      mplier <= {step_sum[0], mplier[WIDTH-1:1]};
      cnt    <= cnt + 1'b1;
    end
  end

  // HI/LO: a committing multiply has priority; software writes only land
  // while idle, and may share an edge with an accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= fix_commit;
      if (fix_commit) begin
        hi <= product[2*WIDTH-1:WIDTH];
        lo <= product[WIDTH-1:0];
      end else if (state == S_IDLE) begin
        if (wr_hi) hi <= wdata;
        if (wr_lo) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer
//   Directed bench for mult_sequencer (WIDTH=32): products against
//   hand-computed values, fixed latency, MTHI/MTLO, and the busy / cancel /
//   reset corner cases.
module tb_mult_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int tests_run;
  int tests_failed;

  mult_sequencer #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .cancel    (cancel),
    .wr_hi     (wr_hi),
    .wr_lo     (wr_lo),
    .wdata     (wdata),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Presents a start for exactly one rising edge; returns at the falling
  // edge right after that edge.
  task automatic applyStimulus(input logic sgn, input logic [31:0] av,
                               input logic [31:0] bv);
    @(negedge clk);
    start     = 1'b1;
    is_signed = sgn;
    a         = av;
    b         = bv;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int pre, output int busy_cycles, output logic seen);
    busy_cycles = pre;
    seen        = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic writeReg(input logic en_hi, input logic en_lo, input logic [31:0] data);
    @(negedge clk);
    wr_hi = en_hi;
    wr_lo = en_lo;
    wdata = data;
    @(negedge clk);
    wr_hi = 1'b0;
    wr_lo = 1'b0;
  endtask

  task automatic runMult(input string tag, input logic sgn, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
    int   cyc;
    logic seen;
    applyStimulus(sgn, av, bv);
    waitDone(0, cyc, seen);
    checkOutput({tag, " done"}, 64'(seen), 64'd1);
    checkOutput({tag, " busy cycles"}, 64'(cyc), 64'd33);
    checkOutput({tag, " hi"}, 64'(hi), 64'(exp_hi));
    checkOutput({tag, " lo"}, 64'(lo), 64'(exp_lo));
    checkOutput({tag, " busy at done"}, 64'(busy), 64'd0);
    @(negedge clk);
    checkOutput({tag, " done one cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    int   cyc;
    logic seen;
    logic done_seen;

    tests_run    = 0;
    tests_failed = 0;
    reset     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    a         = '0;
    b         = '0;
    cancel    = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    wdata     = '0;

    #3;
    checkOutput("reset hi",   64'(hi),   64'd0);
    checkOutput("reset lo",   64'(lo),   64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    #2;
    reset = 1'b1;

    runMult("multu 6*7",     1'b0, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002a);
    runMult("mult -3*5",     1'b1, 32'hfffffffd, 32'h00000005, 32'hffffffff, 32'hfffffff1);
    runMult("mult min*min",  1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    runMult("multu max*max", 1'b0, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 32'h00000001);
    runMult("mult -1*-1",    1'b1, 32'hffffffff, 32'hffffffff, 32'h00000000, 32'h00000001);
    runMult("mult 7*-2",     1'b1, 32'h00000007, 32'hfffffffe, 32'hffffffff, 32'hfffffff2);
    runMult("multu 0*x",     1'b0, 32'h00000000, 32'hdeadbeef, 32'h00000000, 32'h00000000);

    // MTHI / MTLO while idle, then both on the same edge
    writeReg(1'b1, 1'b0, 32'hcafebabe);
    writeReg(1'b0, 1'b1, 32'h12345678);
    checkOutput("mthi idle", 64'(hi), 64'hcafebabe);
    checkOutput("mtlo idle", 64'(lo), 64'h12345678);
    writeReg(1'b1, 1'b1, 32'h5a5a5a5a);
    checkOutput("mthi+mtlo hi", 64'(hi), 64'h5a5a5a5a);
    checkOutput("mthi+mtlo lo", 64'(lo), 64'h5a5a5a5a);
    writeReg(1'b1, 1'b1, 32'hcafebabe);
    writeReg(1'b0, 1'b1, 32'h12345678);

    // Writes during busy are dropped; the product lands later
    applyStimulus(1'b0, 32'd6, 32'd7);
    wr_hi = 1'b1;
    wr_lo = 1'b1;
    wdata = 32'hdeadbeef;
    @(negedge clk);
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    checkOutput("busy write hi", 64'(hi), 64'hcafebabe);
    checkOutput("busy write lo", 64'(lo), 64'h12345678);
    waitDone(0, cyc, seen);
    checkOutput("busy write done", 64'(seen), 64'd1);
    checkOutput("busy write cycles", 64'(cyc), 64'd32);
    checkOutput("busy write result hi", 64'(hi), 64'h0);
    checkOutput("busy write result lo", 64'(lo), 64'h2a);

    // Second start mid-RUN is ignored; latency and product unchanged
    applyStimulus(1'b0, 32'd3, 32'd5);
    cyc = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy) cyc++;
      if (i == 3) begin
        start = 1'b1;
        a     = 32'd9;
        b     = 32'd9;
      end
      if (i == 4) start = 1'b0;
      @(negedge clk);
    end
    waitDone(cyc, cyc, seen);
    checkOutput("restart done", 64'(seen), 64'd1);
    checkOutput("restart cycles", 64'(cyc), 64'd33);
    checkOutput("restart hi", 64'(hi), 64'h0);
    checkOutput("restart lo", 64'(lo), 64'hf);

    // Start and MTHI on the same idle edge: write visible, then overwritten
    @(negedge clk);
    start     = 1'b1;
    is_signed = 1'b0;
    a         = 32'd2;
    b         = 32'd3;
    wr_hi     = 1'b1;
    wdata     = 32'h11111111;
    @(negedge clk);
    start = 1'b0;
    wr_hi = 1'b0;
    checkOutput("start+mthi hi", 64'(hi), 64'h11111111);
    checkOutput("start+mthi busy", 64'(busy), 64'd1);
    waitDone(0, cyc, seen);
    checkOutput("start+mthi done", 64'(seen), 64'd1);
    checkOutput("start+mthi result hi", 64'(hi), 64'h0);
    checkOutput("start+mthi result lo", 64'(lo), 64'h6);

    // Cancel mid-RUN keeps old hi/lo and never pulses done
    writeReg(1'b1, 1'b0, 32'hcafebabe);
    writeReg(1'b0, 1'b1, 32'h12345678);
    applyStimulus(1'b1, 32'hfffffffd, 32'h00000005);
    repeat (4) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checkOutput("cancel busy", 64'(busy), 64'd0);
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      done_seen = done_seen | done;
      @(negedge clk);
    end
    checkOutput("cancel no done", 64'(done_seen), 64'd0);
    checkOutput("cancel hi kept", 64'(hi), 64'hcafebabe);
    checkOutput("cancel lo kept", 64'(lo), 64'h12345678);

    // Cancel together with start in IDLE suppresses the start
    start  = 1'b1;
    cancel = 1'b1;
    a      = 32'd4;
    b      = 32'd4;
    @(negedge clk);
    start  = 1'b0;
    cancel = 1'b0;
    checkOutput("cancel+start busy", 64'(busy), 64'd0);

    // Asynchronous reset partway through RUN
    applyStimulus(1'b0, 32'd6, 32'd7);
    repeat (9) @(negedge clk);
    checkOutput("pre-reset busy", 64'(busy), 64'd1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("async reset busy", 64'(busy), 64'd0);
    checkOutput("async reset hi",   64'(hi),   64'd0);
    checkOutput("async reset lo",   64'(lo),   64'd0);
    @(negedge clk);
    reset = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      done_seen = done_seen | done | busy;
      @(negedge clk);
    end
    checkOutput("reset no done", 64'(done_seen), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
